// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and lane-merge helper for the DRAM arbiter
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2
  } state_t;

  typedef logic master_id_t;

  localparam master_id_t MID_M0 = 1'b0;
  localparam master_id_t MID_M1 = 1'b1;

  // Byte lane i comes from the new data when its enable is set, else from the old word.
  function automatic logic [31:0] lane_merge(input logic [31:0] wdata,
                                             input logic [3:0]  be,
                                             input logic [31:0] old);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-master round-robin arbiter in front of a single-cycle data RAM
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  state_t            r_state, w_state_nxt;
  master_id_t        r_last_grant, w_grant_nxt;
  logic [DATA_W-1:0] r_merge;

  logic              w_req0, w_req1, w_g_req, w_other_req;
  logic [ADDR_W-3:0] w_g_word;
  logic              w_g_read, w_g_write;
  logic [3:0]        w_g_be;
  logic [DATA_W-1:0] w_g_wdata;
  logic              w_g_partial, w_g_full;
  logic              w_load_merge, w_done, w_serve, w_rd_return;
  logic              w_unused_addr_lsbs;

  logic              w_mem_read, w_mem_write;
  logic [ADDR_W-1:0] w_mem_address;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_wait0, w_wait1;
  logic [DATA_W-1:0] w_rdata0, w_rdata1;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Granted master's controls are sampled live; masters hold them until served.
  assign w_g_word    = (r_last_grant == MID_M1) ? m1_address[ADDR_W-1:2] : m0_address[ADDR_W-1:2];
  assign w_g_read    = (r_last_grant == MID_M1) ? m1_read       : m0_read;
  assign w_g_write   = (r_last_grant == MID_M1) ? m1_write      : m0_write;
  assign w_g_be      = (r_last_grant == MID_M1) ? m1_byteenable : m0_byteenable;
  assign w_g_wdata   = (r_last_grant == MID_M1) ? m1_writedata  : m0_writedata;
  assign w_g_req     = w_g_read | w_g_write;
  assign w_other_req = (r_last_grant == MID_M1) ? w_req0 : w_req1;
  assign w_g_full    = (w_g_be == 4'hF);
  assign w_g_partial = (w_g_be != 4'hF) && (w_g_be != 4'h0);

  assign w_unused_addr_lsbs = ^{m0_address[1:0], m1_address[1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= MID_M1;
      r_merge      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_grant_nxt;
      if (w_load_merge) begin
        r_merge <= mem_readdata;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_last_grant;
    w_load_merge  = 1'b0;
    w_done        = 1'b0;
    w_serve       = 1'b0;
    w_rd_return   = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_address = '0;
    w_mem_wdata   = '0;
    w_wait0       = w_req0;
    w_wait1       = w_req1;
    w_rdata0      = '0;
    w_rdata1      = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_grant_nxt = ~r_last_grant;
          w_state_nxt = ST_ACCESS;
        end else if (w_req0) begin
          w_grant_nxt = MID_M0;
          w_state_nxt = ST_ACCESS;
        end else if (w_req1) begin
          w_grant_nxt = MID_M1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!w_g_req) begin
          w_done = 1'b1;
        end else if (w_g_write && w_g_partial) begin
          w_mem_read    = 1'b1;
          w_mem_address = {w_g_word, 2'b00};
          w_load_merge  = 1'b1;
          w_state_nxt   = ST_MERGE;
        end else if (w_g_write) begin
          w_mem_write   = w_g_full;
          w_mem_address = w_g_full ? {w_g_word, 2'b00} : '0;
          w_mem_wdata   = w_g_full ? w_g_wdata : '0;
          w_serve       = 1'b1;
          w_done        = 1'b1;
        end else begin
          w_mem_read    = 1'b1;
          w_mem_address = {w_g_word, 2'b00};
          w_serve       = 1'b1;
          w_rd_return   = 1'b1;
          w_done        = 1'b1;
        end
      end
      ST_MERGE: begin
        if (w_g_req) begin
          w_mem_write   = 1'b1;
          w_mem_address = {w_g_word, 2'b00};
          w_mem_wdata   = lane_merge(w_g_wdata, w_g_be, r_merge);
          w_serve       = 1'b1;
        end
        w_done = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_serve) begin
      if (r_last_grant == MID_M1) w_wait1 = 1'b0;
      else                        w_wait0 = 1'b0;
    end
    if (w_rd_return) begin
      if (r_last_grant == MID_M1) w_rdata1 = mem_readdata;
      else                        w_rdata0 = mem_readdata;
    end

    // Chain straight into the next grant, favouring the other master.
    if (w_done) begin
      if (w_other_req) begin
        w_grant_nxt = ~r_last_grant;
        w_state_nxt = ST_ACCESS;
      end else if (w_g_req) begin
        w_state_nxt = ST_ACCESS;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // Outputs are forced quiet while reset is asserted so an aborted merge never commits.
  assign mem_read       = reset_n & w_mem_read;
  assign mem_write      = reset_n & w_mem_write;
  assign mem_address    = reset_n ? w_mem_address : '0;
  assign mem_writedata  = reset_n ? w_mem_wdata : '0;
  assign m0_waitrequest = reset_n & w_wait0;
  assign m1_waitrequest = reset_n & w_wait1;
  assign m0_readdata    = reset_n ? w_rdata0 : '0;
  assign m1_readdata    = reset_n ? w_rdata1 : '0;

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
  ADDR_W  32  requester and memory address width
  DATA_W  32  data width; fixed at 32
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock; all state on rising edge
  reset_n  in  1  synchronous, active-low reset
  m0_address  in  32  CPU data port byte address
  m0_read  in  1  CPU read request
  m0_write  in  1  CPU write request
  m0_byteenable  in  4  CPU write lane enables
  m0_writedata  in  32  CPU write data
  m0_waitrequest  out  1  high = CPU request not yet served
  m0_readdata  out  32  CPU read data, valid when waitrequest low
  m1_*  same set as m0_*  test-loader/debug port
  mem_address  out  32  to data RAM
  mem_read  out  1  to data RAM
  mem_write  out  1  to data RAM
  mem_writedata  out  32  to data RAM
  mem_readdata  in  32  RAM read data, combinational, same cycle as mem_read

Function
REQ-003 States: IDLE, ACCESS, MERGE; one master granted at a time.
REQ-004 A master is requesting when read or write is high; write and read both high = write only, read ignored.
REQ-005 IDLE, one requester: latch its id, go to ACCESS next cycle.
REQ-006 IDLE, both requesting: grant the master not granted last (round-robin); last_grant resets to 1, so m0 wins the first tie.
REQ-007 ACCESS, read: drive mem_read=1 and mem_address={addr[31:2],2'b00}; pass mem_readdata to mx_readdata; mx_waitrequest low this cycle only.
REQ-008 ACCESS, write with byteenable=4'hF: mem_write=1, mem_writedata=writedata; waitrequest low this cycle; RAM commits at the ending edge.
REQ-009 ACCESS, write with byteenable neither 4'hF nor 4'h0: mem_read=1, capture mem_readdata into merge register, go to MERGE; waitrequest stays high.
REQ-010 MERGE: mem_write=1; each lane from writedata where byteenable=1, else from merge register; waitrequest low this cycle.
REQ-011 Lane i is writedata[8i+7:8i]; no endian swap in the arbiter.
REQ-012 Write with byteenable=4'h0: completes in ACCESS with no memory access, waitrequest low.
REQ-013 After the completing cycle, choose the next grant without passing through IDLE:
  - other master requesting: grant it
  - else same master still requesting: re-grant it
  - else IDLE
REQ-014 Latency: full-word access = 1 wait cycle + 1 completion cycle; partial write = 2 wait cycles + 1 completion cycle.
REQ-015 Masters hold address, data and controls stable until waitrequest low; the arbiter samples them live and does not register them.
REQ-016 Non-granted master's waitrequest = 1 whenever it requests.
REQ-017 Non-requesting master's waitrequest = 0; readdata = 32'h0 when not completing a read.
REQ-018 mem_read and mem_write are never both 1; both 0 in IDLE.

Reset
REQ-019 reset_n low at a rising edge:
  - state=IDLE, last_grant=1, merge register=0
  - mem_read=mem_write=0, mem_address=0, mem_writedata=0
  - both waitrequests=0, both readdata=0
REQ-020 Reset in ACCESS or MERGE aborts the transaction: no mem_write in the cycle after reset; the master must reissue.

Structure
REQ-021 Package dram_arb_pkg SHALL hold the state enum, the master-id typedef and the lane-merge function.
REQ-022 A single flat module is sufficient; lane merge is a package function, not a sub-module.

Verification
REQ-023 m0 reads 0x8 alone, RAM word 2 = 0xAABBCCDD -> m0_waitrequest high 1 cycle, then low with m0_readdata=0xAABBCCDD.
REQ-024 m0 and m1 request the same cycle after reset -> m0 completes first, m1 completes the next cycle, no IDLE between.
REQ-025 m1 writes 0x11223344 to 0x4 with byteenable 4'b0101, RAM word 1 = 0xAABBCCDD -> 2 wait cycles; word 1 becomes 0xAA22CC44.
REQ-026 Both masters request continuously for 6 completions -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-027 reset_n pulsed low during MERGE of a partial write -> RAM word unchanged; all outputs at reset values the following cycle.
REQ-028 m0 asserts read and write together to 0x0 with 0xFFFFFFFF, byteenable 4'hF -> word 0 = 0xFFFFFFFF; only mem_write asserted.
